// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage
//   Pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
//   in_ready comes straight from the skid-valid register, so no combinational
//   ready path runs between stages, and the stage still sustains 1 beat/cycle.
//   The stage also provides stall, flush, bubble insertion on empty output
//   slots, and an occupancy report.
//
// Handshake: a beat moves on a rising clk edge when valid and ready are both 1
//   on that side (push = in_valid & in_ready, pop = out_valid & out_ready &
//   !stall). valid does not depend combinationally on ready. A producer that
//   raises valid holds it and its data until the beat is taken.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset (priority over flush)
//   stall      blocks pop; pushes are still accepted while in_ready=1
//   flush      drops all held beats and any beat pushed in the same cycle
//   in_valid   upstream beat valid
//   in_ready   stage can accept a beat (= !skid_valid & !rst)
//   in_data    upstream payload
//   out_valid  head beat valid (registered)
//   out_ready  downstream accepts head beat
//   out_data   head payload, BUBBLE when out_valid=0
//   occupancy  beats held: 0, 1 or 2 (registered)

module pipe_skid_stage #(
    parameter int unsigned       WIDTH  = 32,
    parameter logic [WIDTH-1:0]  BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // Fill level, taken from {main_valid, skid_valid}.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_ILLEGAL = 2'b01,
        ST_HALF    = 2'b10,
        ST_FULL    = 2'b11
    } fill_state_t;

    logic             main_valid, main_valid_n;
    logic             skid_valid, skid_valid_n;
    logic [WIDTH-1:0] main_data,  main_data_n;
    logic [WIDTH-1:0] skid_data,  skid_data_n;
    logic [1:0]       occ_q,      occ_n;
    logic             push, pop;
    fill_state_t      fill_state;

    assign fill_state = fill_state_t'({main_valid, skid_valid});

    assign in_ready  = !skid_valid && !rst;
    assign out_valid = main_valid;
    assign out_data  = main_valid ? main_data : BUBBLE;
    assign occupancy = occ_q;

    assign push = in_valid && in_ready;
    assign pop  = main_valid && out_ready && !stall;

    always_comb begin
        main_valid_n = main_valid;
        skid_valid_n = skid_valid;
        main_data_n  = main_data;
        skid_data_n  = skid_data;

        if (flush) begin
            // Data registers keep stale values. out_data masks them with BUBBLE.
            main_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end else begin
            case (fill_state)
                ST_EMPTY: begin
                    if (push) begin
                        main_valid_n = 1'b1;
                        main_data_n  = in_data;
                    end
                end
                ST_HALF: begin
                    if (push && !pop) begin
                        skid_valid_n = 1'b1;
                        skid_data_n  = in_data;
                    end else if (push && pop) begin
                        main_data_n  = in_data;
                    end else if (pop) begin
                        main_valid_n = 1'b0;
                    end
                end
                ST_FULL: begin
                    // in_ready is 0 here, so only a pop can happen.
                    if (pop) begin
                        main_data_n  = skid_data;
                        skid_valid_n = 1'b0;
                    end
                end
                default: begin
                    // Skid valid without a head is unreachable. Drop to empty
                    // rather than present an out-of-order beat.
                    main_valid_n = 1'b0;
                    skid_valid_n = 1'b0;
                end
            endcase
        end

        occ_n = {1'b0, main_valid_n} + {1'b0, skid_valid_n};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= BUBBLE;
            skid_data  <= BUBBLE;
            occ_q      <= 2'd0;
        end else begin
            main_valid <= main_valid_n;
            skid_valid <= skid_valid_n;
            main_data  <= main_data_n;
            skid_data  <= skid_data_n;
            occ_q      <= occ_n;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage. The main body is a vector table. Each
// vector gives the inputs applied for one clock edge and the outputs expected
// 1ns after that edge, while those inputs are still applied. A hand-written
// sequence follows that checks FIFO ordering against an expected queue.

module tb_pipe_skid_stage;

    localparam int unsigned      W   = 32;
    localparam logic [W-1:0]     BUB = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst, stall, flush, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_data, out_data;
    logic [1:0]   occupancy;

    int total = 0;
    int bad   = 0;

    pipe_skid_stage #(.WIDTH(W), .BUBBLE(BUB)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic         rst, stall, flush, iv;
        logic [W-1:0] id;
        logic         ordy;
        logic         e_ov;
        logic [W-1:0] e_od;
        logic [1:0]   e_occ;
        logic         e_ir;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic st, input logic fl,
                       input logic iv, input logic [W-1:0] id, input logic ordy,
                       input logic e_ov, input logic [W-1:0] e_od,
                       input logic [1:0] e_occ, input logic e_ir);
        vec_t v;
        v.rst = r; v.stall = st; v.flush = fl; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ; v.e_ir = e_ir;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard for ordering sequence ----------------
    logic [W-1:0] exp_q[$];

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;

        //   rst st fl iv  id            ordy | ov  od            occ  ir
        // 1. reset with in_valid high, then release
        add(1, 0, 0, 1, 32'h55,         0,   0,  BUB,          0,   0);
        add(1, 0, 0, 1, 32'h55,         0,   0,  BUB,          0,   0);
        add(0, 0, 0, 0, 32'h0,          0,   0,  BUB,          0,   1);
        // 2. streaming 0x11..0x18 with out_ready=1
        for (int i = 0; i < 8; i++)
            add(0, 0, 0, 1, 32'h11 + i, 1,   1,  32'h11 + i,   1,   1);
        add(0, 0, 0, 0, 32'h0,          1,   0,  BUB,          0,   1);
        // 3. backpressure: A1, A2 fill; A3 held upstream; then drain in order
        add(0, 0, 0, 1, 32'hA1,         0,   1,  32'hA1,       1,   1);
        add(0, 0, 0, 1, 32'hA2,         0,   1,  32'hA1,       2,   0);
        add(0, 0, 0, 1, 32'hA3,         0,   1,  32'hA1,       2,   0);
        add(0, 0, 0, 1, 32'hA3,         1,   1,  32'hA2,       1,   1);
        add(0, 0, 0, 1, 32'hA3,         1,   1,  32'hA3,       1,   1);
        add(0, 0, 0, 0, 32'h0,          1,   0,  BUB,          0,   1);
        // 4. stall with out_ready=1 absorbs B1, B2; release drains in order
        add(0, 1, 0, 1, 32'hB1,         1,   1,  32'hB1,       1,   1);
        add(0, 1, 0, 1, 32'hB2,         1,   1,  32'hB1,       2,   0);
        add(0, 1, 0, 0, 32'h0,          1,   1,  32'hB1,       2,   0);
        add(0, 0, 0, 0, 32'h0,          1,   1,  32'hB2,       1,   1);
        add(0, 0, 0, 0, 32'h0,          1,   0,  BUB,          0,   1);
        // 5. flush while FULL with C3 offered; C3 never appears
        add(0, 0, 0, 1, 32'hC1,         0,   1,  32'hC1,       1,   1);
        add(0, 0, 0, 1, 32'hC2,         0,   1,  32'hC1,       2,   0);
        add(0, 0, 1, 1, 32'hC3,         0,   0,  BUB,          0,   1);
        add(0, 0, 0, 0, 32'h0,          1,   0,  BUB,          0,   1);
        // 5b. flush while HALF discards a beat pushed in the flush cycle
        add(0, 0, 0, 1, 32'hE1,         0,   1,  32'hE1,       1,   1);
        add(0, 0, 1, 1, 32'hE2,         1,   0,  BUB,          0,   1);
        add(0, 0, 0, 0, 32'h0,          1,   0,  BUB,          0,   1);
        // 6. rst + flush together while HALF, then push D1
        add(0, 0, 0, 1, 32'hD0,         0,   1,  32'hD0,       1,   1);
        add(1, 0, 1, 1, 32'hD9,         0,   0,  BUB,          0,   0);
        add(0, 0, 0, 1, 32'hD1,         0,   1,  32'hD1,       1,   1);
        add(0, 0, 0, 0, 32'h0,          1,   0,  BUB,          0,   1);

        #1;
        foreach (vecs[i]) begin
            rst = vecs[i].rst; stall = vecs[i].stall; flush = vecs[i].flush;
            in_valid = vecs[i].iv; in_data = vecs[i].id; out_ready = vecs[i].ordy;
            step();
            check($sformatf("v%0d.out_valid", i), W'(out_valid), W'(vecs[i].e_ov));
            check($sformatf("v%0d.out_data",  i), out_data,      vecs[i].e_od);
            check($sformatf("v%0d.occupancy", i), W'(occupancy), W'(vecs[i].e_occ));
            check($sformatf("v%0d.in_ready",  i), W'(in_ready),  W'(vecs[i].e_ir));
        end

        // Ordering sequence: six beats under a fixed out_ready/stall pattern.
        // Every pop must match the oldest beat still owed.
        begin
            logic [7:0]   rdy_pat;
            int           sent, popped, cyc;
            logic         did_push, did_pop;
            logic [W-1:0] pop_data;
            rdy_pat = 8'b1011_0010;
            sent = 0; popped = 0; cyc = 0;
            rst = 1'b0; flush = 1'b0;
            while ((sent < 6 || exp_q.size() != 0) && cyc < 80) begin
                in_valid  = (sent < 6);
                in_data   = 32'h60 + sent;
                out_ready = rdy_pat[cyc % 8];
                stall     = (cyc % 5 == 3);
                #1;
                did_push = in_valid && in_ready;
                did_pop  = out_valid && out_ready && !stall;
                pop_data = out_data;
                @(posedge clk);
                #1;
                if (did_pop) begin
                    popped++;
                    if (exp_q.size() == 0) begin
                        check("seq.pop_unexpected", pop_data, BUB);
                    end else begin
                        check($sformatf("seq.pop%0d", popped), pop_data, exp_q.pop_front());
                    end
                end
                if (did_push) begin
                    exp_q.push_back(in_data);
                    sent++;
                end
                cyc++;
            end
            check("seq.sent",      W'(sent),         W'(6));
            check("seq.popped",    W'(popped),       W'(6));
            check("seq.drained",   W'(exp_q.size()), W'(0));
            in_valid = 1'b0; stall = 1'b0; out_ready = 1'b1;
            step();
            check("seq.end_occ",   W'(occupancy),    W'(0));
            check("seq.end_data",  out_data,         BUB);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
